// File: rtl/seq_detector_param_if.sv
// Bit-stream bus for seq_detector_param: qualified serial input, run-time controls and match outputs.
// match_count exists only when SEQ_DET_COUNT_EN is defined.
interface seq_detector_param_if #(
    parameter int CNT_W = 8
) ();
    logic data_in;
    logic data_valid;
    logic overlap;
    logic clear;
    logic y;
    logic y_q;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detector_param_if: CNT_W must be at least 1");
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] match_count;

    modport master (
        output data_in, data_valid, overlap, clear,
        input  y, y_q, match_count
    );
    modport slave (
        input  data_in, data_valid, overlap, clear,
        output y, y_q, match_count
    );
`else
    modport master (
        output data_in, data_valid, overlap, clear,
        input  y, y_q
    );
    modport slave (
        input  data_in, data_valid, overlap, clear,
        output y, y_q
    );
`endif
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised Mealy pattern detector with run-time overlap control and a registered strobe.
// Define SEQ_DET_COUNT_EN to add the saturating match_count output.
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input logic               clk,
    input logic               rst,
    seq_detector_param_if.slave bus
);
    localparam int HW = PAT_LEN - 1;

    if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN must be within 2..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W must be at least 1");
    end

    logic [HW-1:0] hist;
    logic [HW-1:0] hist_nxt;
    logic [5:0]    fill;
    logic          full;
    logic          hit;
    logic          y;
    logic          y_q_r;

    // A two-bit pattern keeps a single bit of history, so there is nothing to shift through.
    if (PAT_LEN == 2) begin : g_hist_one
        assign hist_nxt = bus.data_in;
    end else begin : g_hist_shift
        assign hist_nxt = {hist[HW-2:0], bus.data_in};
    end

    assign full = (fill == 6'(HW));
    assign hit  = ({hist, bus.data_in} == PATTERN);
    assign y    = bus.data_valid & ~bus.clear & full & hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= '0;
            fill  <= '0;
            y_q_r <= 1'b0;
        end else begin
            y_q_r <= y;
            if (bus.clear) begin
                fill <= '0;
            end else if (bus.data_valid) begin
                // Non-overlapping mode: the completing bit belongs to the match and starts nothing new.
                if (y && !bus.overlap) begin
                    fill <= '0;
                end else begin
                    hist <= hist_nxt;
                    if (!full) begin
                        fill <= fill + 6'd1;
                    end
                end
            end
        end
    end

    assign bus.y   = y;
    assign bus.y_q = y_q_r;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (bus.clear) begin
            count <= '0;
        end else if (y && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign bus.match_count = count;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param against a bit-queue reference model.
// Builds with or without SEQ_DET_COUNT_EN.
module tb_seq_detector_param;
    localparam int                 PAT_LEN = 4;
    localparam logic [PAT_LEN-1:0] PATTERN = 4'b1011;
    localparam int                 CNT_W   = 2;
    localparam int unsigned        CMAX    = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    seq_detector_param_if #(.CNT_W(CNT_W)) bus ();

    seq_detector_param #(
        .PAT_LEN(PAT_LEN),
        .PATTERN(PATTERN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the bits accepted since the last flush, newest at the back.
    bit          hq[$];
    int unsigned mcnt   = 0;
    bit          exp_yq = 1'b0;
    bit          obs_y  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit model_y(input bit v, input bit d, input bit c);
        logic [31:0] w;
        if (!v || c || hq.size() != PAT_LEN - 1) return 1'b0;
        w = '0;
        foreach (hq[i]) w = {w[30:0], hq[i]};
        w = {w[30:0], d};
        return w == 32'(PATTERN);
    endfunction

    task automatic model_update(input bit v, input bit d, input bit o, input bit c, input bit ey);
        if (c) begin
            hq.delete();
            mcnt = 0;
        end else if (v) begin
            if (ey && !o) begin
                hq.delete();
            end else begin
                hq.push_back(d);
                if (hq.size() > PAT_LEN - 1) void'(hq.pop_front());
            end
        end
        if (ey && mcnt < CMAX) mcnt++;
    endtask

    task automatic model_reset();
        hq.delete();
        mcnt   = 0;
        exp_yq = 1'b0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the Mealy strobe.
    task automatic step(input bit v, input bit d, input bit o, input bit c);
        bit ey;
        @(negedge clk);
        check("y_q", 32'(bus.y_q), 32'(exp_yq));
`ifdef SEQ_DET_COUNT_EN
        check("match_count", 32'(bus.match_count), mcnt);
`endif
        bus.data_valid = v;
        bus.data_in    = d;
        bus.overlap    = o;
        bus.clear      = c;
        #1;
        ey = model_y(v, d, c);
        check("y", 32'(bus.y), 32'(ey));
        obs_y = bus.y;
        model_update(v, d, o, c, ey);
        exp_yq = ey;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst            = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = 1'b1;
        bus.clear      = 1'b0;
        #1;
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_y_q", 32'(bus.y_q), 32'd0);
`ifdef SEQ_DET_COUNT_EN
        check("rst_count", 32'(bus.match_count), 32'd0);
`endif
        @(negedge clk);
        rst            = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = 1'b0;
        model_reset();
    endtask

    task automatic run_bits(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] ymask, input bit o);
        for (int i = 0; i < n; i++) begin
            step(1'b1, bits[n-1-i], o, 1'b0);
            check(tag, 32'(obs_y), 32'(ymask[n-1-i]));
        end
        step(1'b0, 1'b0, o, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.data_in    = 1'b0;
        bus.data_valid = 1'b0;
        bus.overlap    = 1'b1;
        bus.clear      = 1'b0;
        repeat (2) @(negedge clk);
        check("init_y", 32'(bus.y), 32'd0);
        check("init_y_q", 32'(bus.y_q), 32'd0);
        rst = 1'b0;
        model_reset();

        // T1 overlapping, T2 non-overlapping
        run_bits("t1_y", 16'b1011011, 7, 16'b0001001, 1'b1);
        pulse_rst();
        run_bits("t2_y", 16'b1011011, 7, 16'b0001000, 1'b0);
`ifdef SEQ_DET_COUNT_EN
        check("t2_count", 32'(bus.match_count), 32'd1);
`endif

        // T3 bubbles between every bit
        pulse_rst();
        begin
            logic [3:0] b3;
            b3 = 4'b1011;
            for (int i = 0; i < 4; i++) begin
                step(1'b1, b3[3-i], 1'b1, 1'b0);
                check("t3_y", 32'(obs_y), (i == 3) ? 32'd1 : 32'd0);
                step(1'b0, 1'($urandom), 1'b1, 1'b0);
                check("t3_bubble_y", 32'(obs_y), 32'd0);
            end
        end

        // T4 reset mid-pattern
        pulse_rst();
        run_bits("t4a_y", 16'b101, 3, 16'b000, 1'b1);
        pulse_rst();
        run_bits("t4b_y", 16'b11011, 5, 16'b00001, 1'b1);

        // T5 clear flushes history and discards its bit
        pulse_rst();
        run_bits("t5a_y", 16'b101, 3, 16'b000, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_clear_y", 32'(obs_y), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t5_after_y", 32'(obs_y), 32'd0);

        // T6 five overlapping matches, count saturation and clear
        pulse_rst();
        run_bits("t6_y", 16'b1011011011011011, 16, 16'b0001001001001001, 1'b1);
`ifdef SEQ_DET_COUNT_EN
        check("t6_sat_count", 32'(bus.match_count), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_clear_count", 32'(bus.match_count), 32'd0);
`endif

        // Randomised traffic with occasional clears, resets and overlap changes
        begin
            bit o;
            o = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 99) < 1) begin
                    pulse_rst();
                end else begin
                    if ($urandom_range(0, 99) < 5) o = ~o;
                    step(($urandom_range(0, 9) < 7), 1'($urandom), o,
                         ($urandom_range(0, 99) < 3));
                end
            end
            step(1'b0, 1'b0, o, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
